// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared helpers for the pipeline valid/ready controller
package pipe_ctrl_pkg;

   function automatic int popcount(input logic [31:0] x);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n += int'(x[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/pipe_ctrl_stage.sv
// rtl/pipe_ctrl_stage.sv - one pipeline stage: valid bit, advance term, load enable
module pipe_ctrl_stage #(
   parameter int BUBBLE_COLLAPSE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic up_valid,
   input  logic adv_dn,
   input  logic pipe_adv,
   input  logic flush,
   output logic v,
   output logic adv,
   output logic en
);

   localparam logic BC = (BUBBLE_COLLAPSE != 0);

   logic v_d, v_q;

   // An empty stage can always take the upstream item, even if downstream is stalled.
   assign adv = (BC & (~v_q | adv_dn)) | (~BC & pipe_adv);
   assign en  = adv & ~flush & rst_n;
   assign v   = v_q;

   always_comb begin
      v_d = v_q;
      if (flush) begin
         v_d = 1'b0;
      end else if (en) begin
         v_d = up_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= 1'b0;
      end else begin
         v_q <= v_d;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - valid/ready controller for a chain of enable-gated pipeline registers
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DEPTH           = 4,
   parameter int BUBBLE_COLLAPSE = 1,
   parameter int CNT_W           = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             flush,
   output logic [DEPTH-1:0] stage_en,
   output logic [DEPTH-1:0] stage_valid,
   output logic [CNT_W-1:0] occupancy,
   output logic             busy
);

   logic [DEPTH:0]   adv;
   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] en;
   logic             pipe_adv;
   logic             in_fire;
   logic             out_fire;
   logic [CNT_W-1:0] occ_d, occ_q;

   assign adv[DEPTH] = out_ready;
   // Whole-pipe advance used when bubbles are not collapsed.
   assign pipe_adv   = ~v[DEPTH-1] | out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic up_v;
      if (i == 0) begin : g_first
         assign up_v = in_valid;
      end else begin : g_rest
         assign up_v = v[i-1];
      end

      pipe_ctrl_stage #(
         .BUBBLE_COLLAPSE(BUBBLE_COLLAPSE)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .up_valid (up_v),
         .adv_dn   (adv[i+1]),
         .pipe_adv (pipe_adv),
         .flush    (flush),
         .v        (v[i]),
         .adv      (adv[i]),
         .en       (en[i])
      );
   end

   assign in_ready  = adv[0] & ~flush & rst_n;
   assign out_valid = v[DEPTH-1] & ~flush;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else begin
         occ_d = occ_q + CNT_W'(in_fire) - CNT_W'(out_fire);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign stage_en    = en;
   assign stage_valid = v;
   assign occupancy   = occ_q;
   assign busy        = |occ_q;

   a_occ_popcount: assert property (@(posedge clk) disable iff (!rst_n)
      int'(occ_q) == popcount(32'(v)));

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - table-driven bench with data scoreboard for pipe_ctrl
module tb_pipe_ctrl;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             out_ready;
   logic             flush;
   logic             in_ready;
   logic             out_valid;
   logic [DEPTH-1:0] stage_en;
   logic [DEPTH-1:0] stage_valid;
   logic [CNT_W-1:0] occupancy;
   logic             busy;
   logic             nc_in_ready;
   logic             nc_out_valid;
   logic [DEPTH-1:0] nc_stage_en;
   logic [DEPTH-1:0] nc_stage_valid;
   logic [CNT_W-1:0] nc_occupancy;
   logic             nc_busy;

   always #5 clk = ~clk;

   pipe_ctrl #(.DEPTH(DEPTH), .BUBBLE_COLLAPSE(1), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
      .stage_en(stage_en), .stage_valid(stage_valid), .occupancy(occupancy), .busy(busy)
   );

   pipe_ctrl #(.DEPTH(DEPTH), .BUBBLE_COLLAPSE(0), .CNT_W(CNT_W)) dut_nc (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nc_in_ready),
      .out_valid(nc_out_valid), .out_ready(out_ready), .flush(flush),
      .stage_en(nc_stage_en), .stage_valid(nc_stage_valid), .occupancy(nc_occupancy),
      .busy(nc_busy)
   );

   typedef struct {
      logic       iv, ord, fl;
      logic       ir, ov;
      logic [3:0] sv;
      logic [2:0] occ;
      logic [3:0] en;
      logic       nc_chk, nc_ir;
      logic [3:0] nc_sv;
   } vec_t;

   vec_t        vecs[$];
   int          n_vec = 0;
   int          n_err = 0;
   int unsigned next_id = 0;
   int unsigned sb[$];
   int unsigned data_m[DEPTH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic iv, ord, fl, ir, ov, input logic [3:0] sv,
                      input logic [2:0] occ, input logic [3:0] en,
                      input logic nc_chk, nc_ir, input logic [3:0] nc_sv);
      vec_t r;
      r.iv = iv; r.ord = ord; r.fl = fl; r.ir = ir; r.ov = ov; r.sv = sv;
      r.occ = occ; r.en = en; r.nc_chk = nc_chk; r.nc_ir = nc_ir; r.nc_sv = nc_sv;
      vecs.push_back(r);
   endtask

   task automatic apply(input vec_t r, input int idx);
      logic             fire_in, fire_out, fl_s;
      logic [DEPTH-1:0] en_s;
      int unsigned      d_in, exp_id, nc_pop;
      in_valid  = r.iv;
      out_ready = r.ord;
      flush     = r.fl;
      @(negedge clk);
      check($sformatf("row%0d in_ready", idx), 32'(in_ready), 32'(r.ir));
      check($sformatf("row%0d out_valid", idx), 32'(out_valid), 32'(r.ov));
      check($sformatf("row%0d stage_valid", idx), 32'(stage_valid), 32'(r.sv));
      check($sformatf("row%0d occupancy", idx), 32'(occupancy), 32'(r.occ));
      check($sformatf("row%0d busy", idx), 32'(busy), 32'(r.occ != 0));
      check($sformatf("row%0d stage_en", idx), 32'(stage_en), 32'(r.en));
      if (r.nc_chk) begin
         nc_pop = $countones(r.nc_sv);
         check($sformatf("row%0d nc_in_ready", idx), 32'(nc_in_ready), 32'(r.nc_ir));
         check($sformatf("row%0d nc_stage_valid", idx), 32'(nc_stage_valid), 32'(r.nc_sv));
         check($sformatf("row%0d nc_occupancy", idx), 32'(nc_occupancy), nc_pop);
         check($sformatf("row%0d nc_busy", idx), 32'(nc_busy), 32'(nc_pop != 0));
         check($sformatf("row%0d nc_out_valid", idx), 32'(nc_out_valid), 32'(r.nc_sv[3]));
         check($sformatf("row%0d nc_stage_en", idx), 32'(nc_stage_en), 32'({4{r.nc_ir}}));
      end
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (fire_out) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL row%0d data: got %0d expected none (scoreboard empty)", idx, data_m[DEPTH-1]);
         end else begin
            exp_id = sb.pop_front();
            check($sformatf("row%0d data", idx), data_m[DEPTH-1], exp_id);
         end
      end
      d_in = next_id;
      if (fire_in) begin
         sb.push_back(next_id);
         next_id++;
      end
      en_s = stage_en;
      fl_s = flush;
      @(posedge clk);
      for (int i = DEPTH - 1; i >= 1; i--) begin
         if (en_s[i]) data_m[i] = data_m[i-1];
      end
      if (en_s[0]) data_m[0] = d_in;
      if (fl_s) sb.delete();
      #1;
   endtask

   initial begin
      int n_pre;
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      for (int i = 0; i < DEPTH; i++) data_m[i] = 0;

      // streaming
      add(1,1,0, 1,0,4'b0000,0,4'b1111, 0,0,4'b0000);
      add(1,1,0, 1,0,4'b0001,1,4'b1111, 0,0,4'b0000);
      add(1,1,0, 1,0,4'b0011,2,4'b1111, 0,0,4'b0000);
      add(1,1,0, 1,0,4'b0111,3,4'b1111, 0,0,4'b0000);
      for (int i = 0; i < 6; i++) add(1,1,0, 1,1,4'b1111,4,4'b1111, 0,0,4'b0000);
      // drain
      add(0,1,0, 1,1,4'b1111,4,4'b1111, 0,0,4'b0000);
      add(0,1,0, 1,1,4'b1110,3,4'b1111, 0,0,4'b0000);
      add(0,1,0, 1,1,4'b1100,2,4'b1111, 0,0,4'b0000);
      add(0,1,0, 1,1,4'b1000,1,4'b1111, 0,0,4'b0000);
      add(0,1,0, 1,0,4'b0000,0,4'b1111, 0,0,4'b0000);
      // full stall, then one cycle of out_ready
      add(1,0,0, 1,0,4'b0000,0,4'b1111, 0,0,4'b0000);
      add(1,0,0, 1,0,4'b0001,1,4'b1111, 0,0,4'b0000);
      add(1,0,0, 1,0,4'b0011,2,4'b1111, 0,0,4'b0000);
      add(1,0,0, 1,0,4'b0111,3,4'b1111, 0,0,4'b0000);
      add(1,0,0, 0,1,4'b1111,4,4'b0000, 0,0,4'b0000);
      add(1,0,0, 0,1,4'b1111,4,4'b0000, 0,0,4'b0000);
      add(1,1,0, 1,1,4'b1111,4,4'b1111, 0,0,4'b0000);
      add(0,0,0, 0,1,4'b1111,4,4'b0000, 0,0,4'b0000);
      // flush at occupancy 3
      add(0,1,0, 1,1,4'b1111,4,4'b1111, 0,0,4'b0000);
      add(1,0,1, 0,0,4'b1110,3,4'b0000, 0,0,4'b0000);
      add(0,0,0, 1,0,4'b0000,0,4'b1111, 0,0,4'b0000);
      // bubble: A, idle, B with out_ready low; checks both variants
      add(1,0,0, 1,0,4'b0000,0,4'b1111, 1,1,4'b0000);
      add(0,0,0, 1,0,4'b0001,1,4'b1111, 1,1,4'b0001);
      add(1,0,0, 1,0,4'b0010,1,4'b1111, 1,1,4'b0010);
      add(0,0,0, 1,0,4'b0101,2,4'b1111, 1,1,4'b0101);
      add(0,0,0, 1,1,4'b1010,2,4'b0111, 1,0,4'b1010);
      add(0,0,0, 1,1,4'b1100,2,4'b0011, 1,0,4'b1010);
      add(0,0,0, 1,1,4'b1100,2,4'b0011, 1,0,4'b1010);
      n_pre = vecs.size();
      // stream after reset
      add(1,1,0, 1,0,4'b0000,0,4'b1111, 0,0,4'b0000);
      add(1,1,0, 1,0,4'b0001,1,4'b1111, 0,0,4'b0000);
      add(1,1,0, 1,0,4'b0011,2,4'b1111, 0,0,4'b0000);
      add(1,1,0, 1,0,4'b0111,3,4'b1111, 0,0,4'b0000);
      add(1,1,0, 1,1,4'b1111,4,4'b1111, 0,0,4'b0000);
      add(1,1,0, 1,1,4'b1111,4,4'b1111, 0,0,4'b0000);
      add(0,1,0, 1,1,4'b1111,4,4'b1111, 0,0,4'b0000);
      add(0,1,0, 1,1,4'b1110,3,4'b1111, 0,0,4'b0000);
      add(0,1,0, 1,1,4'b1100,2,4'b1111, 0,0,4'b0000);
      add(0,1,0, 1,1,4'b1000,1,4'b1111, 0,0,4'b0000);
      add(0,1,0, 1,0,4'b0000,0,4'b1111, 0,0,4'b0000);

      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      check("reset stage_valid", 32'(stage_valid), 32'h0);
      check("reset occupancy", 32'(occupancy), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset out_valid", 32'(out_valid), 32'h0);
      check("reset in_ready", 32'(in_ready), 32'h0);
      check("reset stage_en", 32'(stage_en), 32'h0);
      @(posedge clk); #3 rst_n = 1'b1;
      #1 check("first in_ready after reset", 32'(in_ready), 32'h1);

      for (int k = 0; k < n_pre; k++) apply(vecs[k], k);

      // asynchronous reset between edges while holding two items
      in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async stage_valid", 32'(stage_valid), 32'h0);
      check("async occupancy", 32'(occupancy), 32'h0);
      check("async busy", 32'(busy), 32'h0);
      check("async out_valid", 32'(out_valid), 32'h0);
      check("async in_ready", 32'(in_ready), 32'h0);
      check("async stage_en", 32'(stage_en), 32'h0);
      check("async nc_stage_valid", 32'(nc_stage_valid), 32'h0);
      check("async nc_in_ready", 32'(nc_in_ready), 32'h0);
      @(posedge clk); #1;
      check("held stage_valid", 32'(stage_valid), 32'h0);
      check("held in_ready", 32'(in_ready), 32'h0);
      #2 rst_n = 1'b1; in_valid = 1'b0;
      #1;
      check("release in_ready", 32'(in_ready), 32'h1);
      check("release nc_in_ready", 32'(nc_in_ready), 32'h1);
      sb.delete();

      for (int k = n_pre; k < vecs.size(); k++) apply(vecs[k], k);

      check("scoreboard drained", 32'(sb.size()), 32'h0);
      check("final occupancy", 32'(occupancy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
